cipher_stream: RTL and testbench

Streaming, keyed substitution-cipher engine for the alphanumeric display path. It accepts one ASCII character per cycle over a valid/ready handshake and applies a per-character shift drawn from a programmable key table of up to KEY_LEN entries: Caesar with one entry, Vigenère with several. It supports encrypt and decrypt, and emits the result through a registered output stage. It sits between the character source (keyboard/UART buffer) and the display driver.

---
 rtl/cipher_stream.sv | 124 ++++++++++++
 tb/tb_cipher_stream.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cipher_stream.sv
// cipher_stream: keyed Caesar/Vigenere substitution on ASCII alphanumerics.
// The input is accepted over valid/ready and the result is held in a single
// registered output stage. Characters that are not alphanumeric pass through
// unchanged and do not consume a key entry.
module cipher_stream #(
  parameter  int KEY_LEN = 4,
  localparam int IDX_W   = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_wr_en,
  input  logic [IDX_W-1:0] key_wr_addr,
  input  logic [7:0]       key_wr_data,
  input  logic [IDX_W:0]   key_len_cfg,
  input  logic             mode,
  input  logic             restart,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [15:0]      char_count
);

  localparam logic [IDX_W:0] KLEN = (IDX_W+1)'(KEY_LEN);

  logic [7:0]       key_q [KEY_LEN];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             accept;
  logic [IDX_W:0]   len_eff;
  logic [IDX_W-1:0] key_sel;
  logic [7:0]       key_cur;
  logic             is_dig, is_up, is_lo, is_an;
  logic [7:0]       base, modv, shift, off, sum, result;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign char_count = cnt_q;

  assign is_dig = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_up  = (in_data >= 8'h41) && (in_data <= 8'h5A);
  assign is_lo  = (in_data >= 8'h61) && (in_data <= 8'h7A);
  assign is_an  = is_dig || is_up || is_lo;

  // A restart in the accept cycle forces entry 0 for the current character.
  assign key_sel = restart ? '0 : idx_q;
  assign key_cur = key_q[key_sel];

  // Clamp the configured key length into 1..KEY_LEN.
  always_comb begin
    len_eff = key_len_cfg;
    if (key_len_cfg == '0)       len_eff = (IDX_W+1)'(1);
    else if (key_len_cfg > KLEN) len_eff = KLEN;
  end

  // Shift is reduced modulo the class size first, so offset arithmetic stays
  // below 2*M and one conditional subtract finishes the wrap.
  always_comb begin
    base   = is_dig ? 8'h30 : (is_up ? 8'h41 : 8'h61);
    modv   = is_dig ? 8'd10 : 8'd26;
    shift  = key_cur % modv;
    off    = in_data - base;
    sum    = mode ? (off + modv - shift) : (off + shift);
    if (sum >= modv) sum = sum - modv;
    result = is_an ? (base + sum) : in_data;
  end

  // Key index: restart wins over advance; advance wraps at the active length.
  always_comb begin
    idx_d = idx_q;
    if (restart) begin
      idx_d = (accept && is_an && (len_eff > (IDX_W+1)'(1))) ? IDX_W'(1) : '0;
    end else if (accept && is_an) begin
      if (({1'b0, idx_q} + 1'b1) >= len_eff) idx_d = '0;
      else                                   idx_d = idx_q + 1'b1;
    end
  end

  // Output stage and saturating character counter next-state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept && is_an && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      cnt_q       <= 16'h0000;
    end else begin
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
    end
  end

  // Key table; a write lands at the edge, after the current character read it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KEY_LEN; i++) key_q[i] <= 8'h00;
    end else if (key_wr_en && ({1'b0, key_wr_addr} < KLEN)) begin
      key_q[key_wr_addr] <= key_wr_data;
    end
  end

endmodule

// File: tb/tb_cipher_stream.sv
// Testbench for cipher_stream: directed scenarios plus randomized traffic,
// checked every cycle against a character-level reference model.
module tb_cipher_stream;
  localparam int KL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_wr_en;
  logic [1:0]  key_wr_addr;
  logic [7:0]  key_wr_data;
  logic [2:0]  key_len_cfg;
  logic        mode, restart, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data, out_data;
  logic [15:0] char_count;

  cipher_stream #(.KEY_LEN(KL)) dut (
    .clk(clk), .rst(rst), .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr),
    .key_wr_data(key_wr_data), .key_len_cfg(key_len_cfg), .mode(mode),
    .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .char_count(char_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // reference model state
  int          m_key [KL];
  bit          m_ov;
  logic [7:0]  m_od;
  int          m_idx, m_cnt;

  // values to present at the next drive point
  logic        nx_mode = 1'b0;
  logic [2:0]  nx_klen = 3'd1;
  bit          nx_rs = 1'b0, nx_we = 1'b0;
  logic [1:0]  nx_wa = '0;
  logic [7:0]  nx_wd = '0;
  logic [63:0] got_v;

  task automatic mreset();
    for (int i = 0; i < KL; i++) m_key[i] = 0;
    m_ov = 0; m_od = 8'h00; m_idx = 0; m_cnt = 0;
  endtask

  function automatic int eff_len(input int cfg);
    if (cfg == 0) return 1;
    if (cfg > KL) return KL;
    return cfg;
  endfunction

  function automatic bit alnum(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  function automatic logic [7:0] ref_cipher(input logic [7:0] c, input int k, input bit dec);
    int base, m, off, r;
    if (c >= "0" && c <= "9")      begin base = 48; m = 10; end
    else if (c >= "A" && c <= "Z") begin base = 65; m = 26; end
    else if (c >= "a" && c <= "z") begin base = 97; m = 26; end
    else return c;
    off = int'(c) - base;
    if (dec) r = (((off - k) % m) + m) % m;
    else     r = (off + k) % m;
    return 8'(base + r);
  endfunction

  // One clock cycle: check outputs, drive inputs, check in_ready, advance model.
  task automatic step(input bit v, input logic [7:0] d, input bit rdy);
    bit acc;
    int k, len;
    @(negedge clk);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("char_count", char_count, m_cnt);
    in_valid = v; in_data = d; out_ready = rdy;
    mode = nx_mode; key_len_cfg = nx_klen; restart = nx_rs;
    key_wr_en = nx_we; key_wr_addr = nx_wa; key_wr_data = nx_wd;
    nx_rs = 0; nx_we = 0;
    #1;
    chk("in_ready", in_ready, !m_ov || rdy);
    if (out_valid && out_ready) got_v = {got_v[55:0], out_data};
    acc = v && (!m_ov || rdy);
    len = eff_len(int'(key_len_cfg));
    k = m_key[restart ? 0 : m_idx];
    if (acc) begin m_ov = 1; m_od = ref_cipher(d, k, mode); end
    else if (rdy) m_ov = 0;
    if (restart) m_idx = (acc && alnum(d) && len > 1) ? 1 : 0;
    else if (acc && alnum(d)) m_idx = (m_idx + 1 >= len) ? 0 : m_idx + 1;
    if (acc && alnum(d) && m_cnt < 65535) m_cnt++;
    if (key_wr_en && int'(key_wr_addr) < KL) m_key[key_wr_addr] = int'(key_wr_data);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1, s[i], 1);
    step(0, 8'h00, 1);
  endtask

  task automatic wr_key(input logic [1:0] a, input logic [7:0] dd);
    nx_we = 1; nx_wa = a; nx_wd = dd;
    step(0, 8'h00, 1);
  endtask

  task automatic do_restart();
    nx_rs = 1;
    step(0, 8'h00, 1);
  endtask

  initial begin
    rst = 1; key_wr_en = 0; key_wr_addr = '0; key_wr_data = '0; key_len_cfg = 3'd1;
    mode = 0; restart = 0; in_valid = 0; in_data = '0; out_ready = 1;
    mreset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", char_count, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 0;

    // Caesar shift 3
    wr_key(0, 8'd3); nx_klen = 3'd1; nx_mode = 0;
    got_v = '0; send_str("Az9!");
    chk("caesar_str", got_v, "Dc2!");
    chk("caesar_cnt", char_count, 3);

    // Vigenere {1,2}
    wr_key(0, 8'd1); wr_key(1, 8'd2); nx_klen = 3'd2; do_restart();
    got_v = '0; send_str("aaaa");
    chk("vig_str", got_v, "bcbc");
    do_restart();
    got_v = '0; send_str("a!a");
    chk("vig_other", got_v, "b!c");

    // decrypt and large shift
    wr_key(0, 8'd3); nx_klen = 3'd1; nx_mode = 1;
    got_v = '0; send_str("Dc2!");
    chk("decrypt_str", got_v, "Az9!");
    wr_key(0, 8'd255); nx_mode = 0;
    got_v = '0; send_str("A0z");
    chk("shift255", got_v, "V5u");

    // backpressure
    wr_key(0, 8'd1); nx_klen = 3'd2; do_restart();
    got_v = '0;
    step(1, "a", 1);
    repeat (3) step(1, "b", 0);
    chk("bp_hold_data", out_data, "b");
    chk("bp_hold_ready", in_ready, 0);
    step(1, "b", 1); step(1, "c", 1); step(1, "d", 1); step(0, 8'h00, 1);
    chk("bp_str", got_v, "bddf");

    // key write coinciding with an accept
    nx_klen = 3'd1; do_restart();
    got_v = '0;
    nx_we = 1; nx_wa = 0; nx_wd = 8'd5;
    step(1, "a", 1); step(1, "a", 1); step(0, 8'h00, 1);
    chk("wr_same_cycle", got_v, "bf");

    // asynchronous reset with an output pending
    step(1, "a", 1);
    @(posedge clk); #2;
    rst = 1; #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_count", char_count, 0);
    chk("arst_in_ready", in_ready, 1);
    mreset();
    #1 rst = 0;
    nx_klen = 3'd1; nx_mode = 0;
    got_v = '0; send_str("Q");
    chk("post_rst_key0", got_v, "Q");

    // randomized traffic
    for (int it = 0; it < 600; it++) begin
      logic [7:0] d;
      int cls;
      nx_mode = 1'($urandom);
      nx_klen = 3'($urandom_range(0, 7));
      nx_rs = ($urandom % 10) == 0;
      if (($urandom % 6) == 0) begin
        nx_we = 1; nx_wa = 2'($urandom); nx_wd = 8'($urandom);
      end
      cls = $urandom % 4;
      case (cls)
        0:       d = 8'($urandom_range(48, 57));
        1:       d = 8'($urandom_range(65, 90));
        2:       d = 8'($urandom_range(97, 122));
        default: d = 8'($urandom);
      endcase
      step(($urandom % 4) != 0, d, ($urandom % 3) != 0);
    end
    step(0, 8'h00, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
